branch_ctrl_unit: RTL and testbench
===================================

BRANCH_CTRL_UNIT -- requirements
Module: branch_ctrl_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter and target width in bits.
REQ-002 SHALL have parameter FLAG_W, default 4, meaning ALU flag vector width; bit3=carry, bit2=overflow, bit1=zero, bit0=negative.
REQ-003 SHALL have parameter FLUSH_STAGES, default 2, range 1..4, meaning number of pipe registers cleared per redirect.
REQ-004 SHALL have parameter CNT_W, default 16, meaning taken-branch counter width.
REQ-005 SHALL use one clock, clk_i, with asynchronous active-low reset rst_n_i; ports: clk_i input 1 clock; rst_n_i input 1 async active-low reset.
REQ-006 SHALL have port branchsel_id_i, input, 3 bits: branch code of the instruction in ID.
REQ-007 SHALL have port branchsel_ex_i, input, 3 bits: branch code of the instruction in EX.
REQ-008 SHALL have port ex_valid_i, input, 1 bit: EX holds a valid instruction.
REQ-009 SHALL have port alu_flags_i, input, FLAG_W bits: flags from the EX ALU.
REQ-010 SHALL have ports target_id_i and target_ex_i, input, PC_W bits each: jump/branch target addresses.
REQ-011 SHALL have port fetch_ready_i, input, 1 bit: fetch accepts a PC load this cycle.
REQ-012 SHALL have port pc_load_o, output, 1 bit: redirect request to fetch.
REQ-013 SHALL have port pc_target_o, output, PC_W bits: redirect address.
REQ-014 SHALL have port clear_pipes_o, output, FLUSH_STAGES bits: per-stage clear, bit0 = IF/ID.
REQ-015 SHALL have port stall_o, output, 1 bit: freeze IF/ID while a redirect is pending.
REQ-016 SHALL have port taken_cnt_o, output, CNT_W bits: number of taken redirects.

Function
REQ-017 SHALL decode codes as follows: 000 none; 001 unconditional jump (ID); 010 zero; 011 negative; 100 !zero; 101 !negative; 110 carry; 111 overflow (all EX, 010..111 conditional).
REQ-018 SHALL treat an EX condition as taken only when ex_valid_i=1 and the selected flag test is true.
REQ-019 SHALL give a taken EX branch priority over a simultaneous ID jump, and the ID jump SHALL be discarded because it is flushed.
REQ-020 SHALL register the decision: a redirect detected in cycle N drives pc_load_o=1 and pc_target_o in cycle N+1 (latency 1).
REQ-021 SHALL implement FSM states IDLE, REDIRECT, and FLUSH.
REQ-022 SHALL transition IDLE->REDIRECT on a taken decision, latching the target.
REQ-023 SHALL hold pc_load_o=1, stall_o=1, and a stable target in REDIRECT until fetch_ready_i=1, then go to FLUSH.
REQ-024 SHALL assert, in FLUSH, clear_pipes_o bit k on the k-th FLUSH cycle cumulatively (all bits 0..k) using a down-counter loaded with FLUSH_STAGES-1, and SHALL return to IDLE when the count reaches 0.
REQ-025 SHALL ignore branch codes arriving in REDIRECT or FLUSH, because those instructions are being squashed.
REQ-026 SHALL increment taken_cnt_o once per REDIRECT->FLUSH handshake, and the counter SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 SHALL read flag bits above FLAG_W-1 as 0 when FLAG_W<4.
REQ-028 SHALL drive pc_load_o=0, stall_o=0, and clear_pipes_o=0 in IDLE.

Reset
REQ-029 SHALL, while rst_n_i=0 (asynchronously), put the FSM in IDLE and set pc_load_o=0, pc_target_o=0, clear_pipes_o=0, stall_o=0, taken_cnt_o=0, and the flush counter to 0.
REQ-030 SHALL abandon a redirect pending when reset asserts, with no pc_load_o after release until a new decision occurs.

Structure
REQ-031 SHALL take branch codes (enum br_code_t), flag bit indices, and FSM state enum from shared package cpu_pkg.
REQ-032 SHALL implement condition evaluation as one combinational sub-module, branch_cond_eval (code, flags, valid -> taken).

Verification
REQ-033 SHALL cover: branchsel_ex_i=010, flags=0010, ex_valid_i=1, target_ex_i=0x40, fetch_ready_i=1 -> next cycle pc_load_o=1, pc_target_o=0x40; then clear_pipes_o=01, then 11; taken_cnt_o=1.
REQ-034 SHALL cover: branchsel_ex_i=100 with zero=1 -> no pc_load_o, clear_pipes_o stays 0.
REQ-035 SHALL cover: branchsel_id_i=001 (target 0x80) and taken EX 011 (target 0x20) in the same cycle -> pc_target_o=0x20 only, one redirect.
REQ-036 SHALL cover: fetch_ready_i=0 for 3 cycles after a redirect -> pc_load_o and stall_o held for 3 cycles, target stable, and a new branch code during the hold is ignored.
REQ-037 SHALL cover: rst_n_i pulsed low while in REDIRECT -> all outputs 0 immediately, and no pc_load_o after release.
REQ-038 SHALL cover: CNT_W=2 with 5 taken branches -> taken_cnt_o=1 (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch codes, ALU flag bit positions and the
// branch-control FSM state encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'b000,
    BR_JUMP  = 3'b001,
    BR_ZERO  = 3'b010,
    BR_NEG   = 3'b011,
    BR_NZERO = 3'b100,
    BR_NNEG  = 3'b101,
    BR_CARRY = 3'b110,
    BR_OVF   = 3'b111
  } br_code_t;

  localparam int NUM_FLAGS  = 4;
  localparam int FLAG_NEG   = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDIRECT,
    ST_FLUSH
  } bcu_state_t;

  function automatic logic is_id_jump(input logic [2:0] code);
    return br_code_t'(code) == BR_JUMP;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// EX-stage branch condition test: code + ALU flags + valid -> taken.
// Purely combinational; flag bits beyond FLAG_W read as 0.
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [2:0]        code_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic              valid_i,
  output logic              taken_o
);

  logic [NUM_FLAGS-1:0] f;

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    if (i < FLAG_W) begin : g_pass
      assign f[i] = flags_i[i];
    end else begin : g_zero
      assign f[i] = 1'b0;
    end
  end

  always_comb begin
    taken_o = 1'b0;
    case (br_code_t'(code_i))
      BR_ZERO:  taken_o = f[FLAG_ZERO];
      BR_NEG:   taken_o = f[FLAG_NEG];
      BR_NZERO: taken_o = ~f[FLAG_ZERO];
      BR_NNEG:  taken_o = ~f[FLAG_NEG];
      BR_CARRY: taken_o = f[FLAG_CARRY];
      BR_OVF:   taken_o = f[FLAG_OVF];
      default:  taken_o = 1'b0;
    endcase
    // An empty EX slot can never redirect, whatever its stale code says.
    if (!valid_i) taken_o = 1'b0;
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// Branch redirect control: picks EX branch over ID jump, redirects fetch 1 cycle later,
// holds the request (stall) until fetch_ready_i, then clears FLUSH_STAGES pipe regs.
module branch_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLAG_W       = 4,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [2:0]              branchsel_id_i,
  input  logic [2:0]              branchsel_ex_i,
  input  logic                    ex_valid_i,
  input  logic [FLAG_W-1:0]       alu_flags_i,
  input  logic [PC_W-1:0]         target_id_i,
  input  logic [PC_W-1:0]         target_ex_i,
  input  logic                    fetch_ready_i,
  output logic                    pc_load_o,
  output logic [PC_W-1:0]         pc_target_o,
  output logic [FLUSH_STAGES-1:0] clear_pipes_o,
  output logic                    stall_o,
  output logic [CNT_W-1:0]        taken_cnt_o
);

  localparam int                FCNT_W    = 2;
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_STAGES - 1);

  bcu_state_t        state_q, state_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ex_taken;
  logic              id_jump;
  logic              handshake;

  branch_cond_eval #(
    .FLAG_W (FLAG_W)
  ) u_cond (
    .code_i  (branchsel_ex_i),
    .flags_i (alu_flags_i),
    .valid_i (ex_valid_i),
    .taken_o (ex_taken)
  );

  assign id_jump = is_id_jump(branchsel_id_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
      if (handshake) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    fcnt_d        = fcnt_q;
    handshake     = 1'b0;
    pc_load_o     = 1'b0;
    stall_o       = 1'b0;
    clear_pipes_o = '0;
    case (state_q)
      ST_IDLE: begin
        // EX is older than ID, so a taken EX branch wins and squashes the ID jump.
        if (ex_taken) begin
          state_d  = ST_REDIRECT;
          target_d = target_ex_i;
        end else if (id_jump) begin
          state_d  = ST_REDIRECT;
          target_d = target_id_i;
        end
      end
      ST_REDIRECT: begin
        pc_load_o = 1'b1;
        stall_o   = 1'b1;
        if (fetch_ready_i) begin
          handshake = 1'b1;
          state_d   = ST_FLUSH;
          fcnt_d    = FCNT_INIT;
        end
      end
      ST_FLUSH: begin
        // Flush cycle k = FLUSH_STAGES-1-fcnt clears stages 0..k.
        for (int k = 0; k < FLUSH_STAGES; k++) begin
          clear_pipes_o[k] = (k + int'(fcnt_q) <= FLUSH_STAGES - 1);
        end
        if (fcnt_q == '0) state_d = ST_IDLE;
        else              fcnt_d  = fcnt_q - FCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc_target_o = target_q;
  assign taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Bench for branch_ctrl_unit: default instance plus a narrow one (FLAG_W=3, FLUSH_STAGES=3, CNT_W=2),
// both driven by the same stimulus and compared each cycle to a transaction-level reference.
module tb_branch_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel_id, sel_ex;
  logic        ex_valid;
  logic [3:0]  flags;
  logic [31:0] t_id, t_ex;
  logic        fetch_ready;

  logic        pc_load0, stall0;
  logic [31:0] pc_tgt0;
  logic [1:0]  clr0;
  logic [15:0] cnt0;
  logic        pc_load1, stall1;
  logic [15:0] pc_tgt1;
  logic [2:0]  clr1;
  logic [1:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_ctrl_unit dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .branchsel_id_i(sel_id), .branchsel_ex_i(sel_ex), .ex_valid_i(ex_valid),
    .alu_flags_i(flags), .target_id_i(t_id), .target_ex_i(t_ex),
    .fetch_ready_i(fetch_ready),
    .pc_load_o(pc_load0), .pc_target_o(pc_tgt0), .clear_pipes_o(clr0),
    .stall_o(stall0), .taken_cnt_o(cnt0)
  );

  branch_ctrl_unit #(.PC_W(16), .FLAG_W(3), .FLUSH_STAGES(3), .CNT_W(2)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .branchsel_id_i(sel_id), .branchsel_ex_i(sel_ex), .ex_valid_i(ex_valid),
    .alu_flags_i(flags[2:0]), .target_id_i(t_id[15:0]), .target_ex_i(t_ex[15:0]),
    .fetch_ready_i(fetch_ready),
    .pc_load_o(pc_load1), .pc_target_o(pc_tgt1), .clear_pipes_o(clr1),
    .stall_o(stall1), .taken_cnt_o(cnt1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: per instance, "redirect pending" flag, position inside the flush
  // window (0 = not flushing), latched target and taken count.
  bit          m_red  [2];
  int          m_fpos [2];
  logic [31:0] m_tgt  [2];
  int          m_cnt  [2];

  function automatic int fs_of(int m);         return (m == 1) ? 3 : 2; endfunction
  function automatic int cnt_mod(int m);       return (m == 1) ? 4 : 65536; endfunction
  function automatic logic [31:0] pc_mask(int m); return (m == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF; endfunction

  function automatic bit cond_taken(int m, logic [2:0] code, logic [3:0] fl, logic v);
    logic [3:0] f;
    f = fl & ((m == 1) ? 4'b0111 : 4'b1111);
    if (!v) return 1'b0;
    case (code)
      3'd2:    return f[1];
      3'd3:    return f[0];
      3'd4:    return !f[1];
      3'd5:    return !f[0];
      3'd6:    return f[3];
      3'd7:    return f[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_red[m] = 1'b0; m_fpos[m] = 0; m_tgt[m] = '0; m_cnt[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (m_red[m]) begin
        if (fetch_ready) begin
          m_red[m]  = 1'b0;
          m_fpos[m] = 1;
          m_cnt[m]  = (m_cnt[m] + 1) % cnt_mod(m);
        end
      end else if (m_fpos[m] > 0) begin
        m_fpos[m] = (m_fpos[m] == fs_of(m)) ? 0 : m_fpos[m] + 1;
      end else if (cond_taken(m, sel_ex, flags, ex_valid)) begin
        m_red[m] = 1'b1; m_tgt[m] = t_ex & pc_mask(m);
      end else if (sel_id == 3'd1) begin
        m_red[m] = 1'b1; m_tgt[m] = t_id & pc_mask(m);
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("pc_load0", pc_load0, m_red[0]);
    check_eq("stall0",   stall0,   m_red[0]);
    check_eq("clear0",   clr0,     (32'd1 << m_fpos[0]) - 1);
    check_eq("cnt0",     cnt0,     m_cnt[0]);
    if (m_red[0]) check_eq("target0", pc_tgt0, m_tgt[0]);
    check_eq("pc_load1", pc_load1, m_red[1]);
    check_eq("stall1",   stall1,   m_red[1]);
    check_eq("clear1",   clr1,     (32'd1 << m_fpos[1]) - 1);
    check_eq("cnt1",     cnt1,     m_cnt[1]);
    if (m_red[1]) check_eq("target1", pc_tgt1, m_tgt[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    sel_id = 3'd0; sel_ex = 3'd0; ex_valid = 1'b0; flags = 4'd0;
    t_id = '0; t_ex = '0; fetch_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_tgt0", pc_tgt0, 32'd0);
    check_eq("rst_tgt1", pc_tgt1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12; i++) begin
      if (!m_red[0] && !m_red[1] && m_fpos[0] == 0 && m_fpos[1] == 0) break;
      cycle();
    end
  endtask

  task automatic take_ex(input logic [2:0] code, input logic [3:0] fl, input logic [31:0] tgt);
    sel_ex = code; flags = fl; ex_valid = 1'b1; t_ex = tgt;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Taken zero branch with fetch ready: load, then cumulative clears.
    take_ex(3'd2, 4'b0010, 32'h40);
    cycle();
    idle_inputs();
    check_eq("r33_load", pc_load0, 1'b1);
    check_eq("r33_tgt",  pc_tgt0, 32'h40);
    cycle();
    check_eq("r33_clr01", clr0, 2'b01);
    cycle();
    check_eq("r33_clr11", clr0, 2'b11);
    check_eq("r33_cnt", cnt0, 16'd1);
    wait_idle();

    // Not-zero branch with zero set: not taken.
    take_ex(3'd4, 4'b0010, 32'h55);
    cycle();
    idle_inputs();
    check_eq("r34_load", pc_load0, 1'b0);
    cycle();
    check_eq("r34_clr", clr0, 2'b00);

    // ID jump and taken EX branch together: EX wins, single redirect.
    sel_id = 3'd1; t_id = 32'h80;
    take_ex(3'd3, 4'b0001, 32'h20);
    cycle();
    idle_inputs();
    check_eq("r35_tgt", pc_tgt0, 32'h20);
    wait_idle();
    check_eq("r35_cnt", cnt0, 16'd2);

    // Fetch not ready for 3 cycles; new codes during the hold are ignored.
    take_ex(3'd2, 4'b0010, 32'h100);
    cycle();
    fetch_ready = 1'b0;
    sel_id = 3'd1; t_id = 32'h999;
    take_ex(3'd7, 4'b1111, 32'h777);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("r36_load", pc_load0, 1'b1);
      check_eq("r36_stall", stall0, 1'b1);
      check_eq("r36_tgt", pc_tgt0, 32'h100);
    end
    idle_inputs();
    wait_idle();
    check_eq("r36_after", pc_load0, 1'b0);

    // Reset pulse while a redirect is pending.
    take_ex(3'd5, 4'b0000, 32'h44);
    fetch_ready = 1'b0;
    cycle();
    check_eq("r37_pending", pc_load0, 1'b1);
    idle_inputs();
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    check_eq("r37_noload", pc_load0, 1'b0);

    // Five taken branches: 2-bit counter wraps to 1.
    for (int i = 0; i < 5; i++) begin
      take_ex(3'd2, 4'b0010, 32'h10 * (i + 1));
      cycle();
      idle_inputs();
      wait_idle();
    end
    check_eq("r38_cnt1", cnt1, 2'd1);
    check_eq("r38_cnt0", cnt0, 16'd5);

    // Carry branch: taken on the 4-flag unit, carry reads 0 on the 3-flag unit.
    take_ex(3'd6, 4'b1000, 32'h1234);
    cycle();
    idle_inputs();
    check_eq("carry_w4", pc_load0, 1'b1);
    check_eq("carry_w3", pc_load1, 1'b0);
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      sel_id      = 3'($urandom_range(0, 7));
      sel_ex      = 3'($urandom_range(0, 7));
      ex_valid    = 1'($urandom_range(0, 1));
      flags       = 4'($urandom_range(0, 15));
      t_id        = $urandom;
      t_ex        = $urandom;
      fetch_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
